aukv_dmem_bridge: RTL and testbench
===================================

Name: aukv_dmem_bridge

Overview:
Data-memory bridge directly downstream of the memory-access stage. It consumes that stage's data-memory request (en/we/addr/strobe/data) and drives a single-port synchronous word SRAM. Store data and byte enables are aligned to the byte address, read data is right-aligned back to lane 0, and a one-cycle valid pulse returns to the stage. Configurable wait states; misaligned accesses are detected.

Parameters:
ADDR_W, 12, SRAM word-address width (byte address bits [ADDR_W+1:2] used)
WAIT_CYCLES, 0, extra SRAM read-latency cycles beyond 1 (range 0..15)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, synchronous, active-high
i_en  in  1  request enable from mem stage
i_we  in  1  1=store, 0=load
i_addr  in  32  byte address
i_strobe  in  4  lane-0-based size mask: 1=byte, 3=half, F=word
i_wdata  in  32  lane-0-based store data
o_rdata  out  32  load data, lane-0-aligned (mem stage sign/zero-extends)
o_valid  out  1  one-cycle completion pulse
o_err  out  1  misaligned flag, coincident with o_valid
o_busy  out  1  high in any non-IDLE state
o_sram_en  out  1  SRAM access strobe
o_sram_be  out  4  SRAM byte write enables (0 for loads)
o_sram_addr  out  ADDR_W  SRAM word address
o_sram_wdata  out  32  SRAM write data
i_sram_rdata  in  32  SRAM read word, valid 1+WAIT_CYCLES cycles after o_sram_en, held until next access

Behaviour:
- Clock i_clk, reset i_rst: one clock; reset synchronous, active-high. Reset values: all outputs 0, state IDLE, counter 0, capture regs 0.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: i_en=1 at an edge -> latch we, addr[1:0], word address, strobe, wdata. Misaligned (strobe=F and addr[1:0]!=0, or strobe=3 and addr[0]=1) -> RESP with err flag set, capture reg = 0. Otherwise -> ACCESS. i_en=0 -> stay IDLE.
- ACCESS (1 cycle): o_sram_en=1; o_sram_addr=latched word address; stores: o_sram_be = strobe << addr[1:0], o_sram_wdata = wdata << 8*addr[1:0]; loads: be=0. Unconditionally -> WAIT, counter cleared.
- WAIT: o_sram_en=0, be=0. The counter increments each cycle. At the edge where counter==WAIT_CYCLES, capture i_sram_rdata >> 8*addr[1:0] (zero-fill) and go to RESP. WAIT therefore lasts WAIT_CYCLES+1 cycles.
- RESP (1 cycle): o_valid=1; o_rdata = capture reg; o_err = err flag. -> IDLE. Stores also return a valid pulse; o_rdata is don't-care but is driven from the capture reg.
- Latency: accept edge to o_valid high = WAIT_CYCLES+3 cycles (normal). For misaligned accesses it is 1 cycle, with no SRAM access and no write.
- i_en is ignored in ACCESS/WAIT/RESP. This absorbs the mem stage holding en for two cycles after issue and en being masked the cycle after valid. It also enforces one outstanding request.
- o_sram_addr/o_sram_wdata hold their latched values outside ACCESS; only o_sram_en/o_sram_be qualify the access.
- o_rdata/o_err hold their last values outside RESP. Consumers qualify them with o_valid.
- strobe=0 with we=1: access performed with be=0 (no write), valid returned, err=0.
- Reset asserted mid-operation: next edge forces IDLE and deasserts o_sram_en/o_valid/o_err. No response is ever issued for the aborted request.
- Address bits above ADDR_W+1 are ignored (aliasing); no range error.

Test Plan:
- Reset then aligned lw: SRAM word 0x10 = 0xDEADBEEF, i_en=1, we=0, addr=0x40, strobe=F, W=0 -> o_sram_en one cycle with addr 0x10, be=0. o_valid 3 cycles after accept, o_rdata=0xDEADBEEF, err=0.
- sb at addr 0x43, wdata=0x000000A5 -> o_sram_be=8, o_sram_wdata=0xA5000000. Subsequent lbu at 0x43 returns o_rdata=0x000000A5.
- sh at 0x102, wdata=0x1234 -> be=C, wdata=0x12340000. lh at 0x102 returns 0x00001234. lh at 0x101 -> o_valid+o_err 1 cycle after accept, no o_sram_en, rdata=0.
- WAIT_CYCLES=3: lw -> o_valid exactly 6 cycles after accept. i_en held high for 2 extra cycles after accept causes no second o_sram_en.
- Back-to-back: a second request presented the cycle after o_valid is accepted only from IDLE. Each request yields exactly one o_sram_en and one o_valid.
- i_rst pulsed during WAIT -> o_busy=0, o_valid never asserts for that request. A fresh lw afterwards completes normally.

Source files
------------

// File: rtl/aukv_dmem_bridge_if.sv
// Request/response and SRAM-side signals of the data-memory bridge.
// slave  : the bridge itself (consumes mem-stage request, drives SRAM).
// master : the mem stage plus the SRAM macro (drives request and SRAM read data).
// Signals: i_en/i_we/i_addr/i_strobe/i_wdata request; o_rdata/o_valid/o_err/o_busy
// response; o_sram_en/o_sram_be/o_sram_addr/o_sram_wdata/i_sram_rdata SRAM port.
interface aukv_dmem_bridge_if #(
  parameter int ADDR_W = 12
);
  logic              i_en;
  logic              i_we;
  logic [31:0]       i_addr;
  logic [3:0]        i_strobe;
  logic [31:0]       i_wdata;
  logic [31:0]       o_rdata;
  logic              o_valid;
  logic              o_err;
  logic              o_busy;
  logic              o_sram_en;
  logic [3:0]        o_sram_be;
  logic [ADDR_W-1:0] o_sram_addr;
  logic [31:0]       o_sram_wdata;
  logic [31:0]       i_sram_rdata;

  modport slave (
    input  i_en, i_we, i_addr, i_strobe, i_wdata, i_sram_rdata,
    output o_rdata, o_valid, o_err, o_busy,
    output o_sram_en, o_sram_be, o_sram_addr, o_sram_wdata
  );

  modport master (
    output i_en, i_we, i_addr, i_strobe, i_wdata, i_sram_rdata,
    input  o_rdata, o_valid, o_err, o_busy,
    input  o_sram_en, o_sram_be, o_sram_addr, o_sram_wdata
  );
endinterface

// File: rtl/aukv_dmem_bridge.sv
// Data-memory bridge between the memory-access stage and a single-port
// synchronous word SRAM. Aligns store data / byte enables to the byte address,
// right-aligns load data to lane 0, returns a one-cycle o_valid pulse, and
// flags misaligned half/word accesses without touching the SRAM.
// Ports: i_clk (rising edge), i_rst (sync, active-high), bus (slave modport of
// aukv_dmem_bridge_if carrying the request, response and SRAM signals).
// Params: ADDR_W SRAM word-address width; WAIT_CYCLES extra read latency (0..15).
module aukv_dmem_bridge #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 0
) (
  input logic                i_clk,
  input logic                i_rst,
  aukv_dmem_bridge_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t     state;
  logic [3:0] cnt;
  logic [1:0] off_q;

  logic        misalign;
  logic [6:0]  be_wide;
  logic [3:0]  be_al;
  logic [31:0] wdata_al;
  logic [31:0] rdata_al;

  assign misalign = ((bus.i_strobe == 4'hF) && (bus.i_addr[1:0] != 2'd0)) ||
                    ((bus.i_strobe == 4'h3) && bus.i_addr[0]);
  // Lanes shifted past byte 3 are dropped; only malformed strobes reach them.
  assign be_wide  = {3'b000, bus.i_strobe} << bus.i_addr[1:0];
  assign be_al    = be_wide[3:0];
  assign wdata_al = bus.i_wdata << {bus.i_addr[1:0], 3'b000};
  assign rdata_al = bus.i_sram_rdata >> {off_q, 3'b000};

  assign bus.o_busy = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= IDLE;
      cnt              <= 4'd0;
      off_q            <= 2'd0;
      bus.o_rdata      <= 32'd0;
      bus.o_valid      <= 1'b0;
      bus.o_err        <= 1'b0;
      bus.o_sram_en    <= 1'b0;
      bus.o_sram_be    <= 4'd0;
      bus.o_sram_addr  <= '0;
      bus.o_sram_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: if (bus.i_en) begin
          off_q            <= bus.i_addr[1:0];
          bus.o_sram_addr  <= bus.i_addr[ADDR_W+1:2];
          bus.o_sram_wdata <= wdata_al;
          if (misalign) begin
            // Short-circuit to the response; SRAM is never touched.
            bus.o_rdata <= 32'd0;
            bus.o_err   <= 1'b1;
            bus.o_valid <= 1'b1;
            state       <= RESP;
          end else begin
            bus.o_sram_en <= 1'b1;
            bus.o_sram_be <= bus.i_we ? be_al : 4'd0;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          bus.o_sram_en <= 1'b0;
          bus.o_sram_be <= 4'd0;
          cnt           <= 4'd0;
          state         <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 4'd1;
          if (cnt == WAIT_LAST) begin
            bus.o_rdata <= rdata_al;
            bus.o_err   <= 1'b0;
            bus.o_valid <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          bus.o_valid <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aukv_dmem_bridge.sv
module tb_aukv_dmem_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // index 0: WAIT_CYCLES=0, index 1: WAIT_CYCLES=3
  logic        rst       [2];
  logic        en        [2];
  logic        we        [2];
  logic [31:0] addr      [2];
  logic [3:0]  strb      [2];
  logic [31:0] wdat      [2];
  logic [31:0] rdata     [2];
  logic        valid     [2];
  logic        err       [2];
  logic        busy      [2];
  logic        sram_en   [2];
  logic [3:0]  sram_be   [2];
  logic [11:0] sram_addr [2];
  logic [31:0] sram_wd   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int W = (g == 0) ? 0 : 3;
    aukv_dmem_bridge_if #(.ADDR_W(12)) bus ();
    logic [31:0] mem [4096];
    logic [31:0] sram_q = 32'd0;
    logic [31:0] pdata  = 32'd0;
    int          pend   = 0;

    assign bus.i_en         = en[g];
    assign bus.i_we         = we[g];
    assign bus.i_addr       = addr[g];
    assign bus.i_strobe     = strb[g];
    assign bus.i_wdata      = wdat[g];
    assign bus.i_sram_rdata = sram_q;
    assign rdata[g]     = bus.o_rdata;
    assign valid[g]     = bus.o_valid;
    assign err[g]       = bus.o_err;
    assign busy[g]      = bus.o_busy;
    assign sram_en[g]   = bus.o_sram_en;
    assign sram_be[g]   = bus.o_sram_be;
    assign sram_addr[g] = bus.o_sram_addr;
    assign sram_wd[g]   = bus.o_sram_wdata;

    aukv_dmem_bridge #(.ADDR_W(12), .WAIT_CYCLES(W)) dut (
      .i_clk (clk),
      .i_rst (rst[g]),
      .bus   (bus.slave)
    );

    initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
      mem[12'h010] = 32'hDEADBEEF;
    end

    // SRAM model: read word valid 1+W edges after the enable edge, garbage before.
    always @(posedge clk) begin
      if (bus.o_sram_en) begin
        for (int i = 0; i < 4; i++)
          if (bus.o_sram_be[i]) mem[bus.o_sram_addr][8*i +: 8] <= bus.o_sram_wdata[8*i +: 8];
        if (W == 0) sram_q <= mem[bus.o_sram_addr];
        else begin
          sram_q <= 32'hBADBAD00;
          pdata  <= mem[bus.o_sram_addr];
          pend   <= W;
        end
      end else if (pend != 0) begin
        pend <= pend - 1;
        if (pend == 1) sram_q <= pdata;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Present one request, hold en for 'hold' cycles after accept, observe 25 cycles.
  task automatic run_req(input int d, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] wd, input int hold,
                         output int lat, output int ens, output int vals,
                         output logic [3:0] be_o, output logic [11:0] sa_o,
                         output logic [31:0] sw_o, output logic [31:0] rd_o,
                         output logic err_o);
    @(negedge clk);
    en[d] = 1'b1; we[d] = w; addr[d] = a; strb[d] = s; wdat[d] = wd;
    lat = 0; ens = 0; vals = 0;
    be_o = 4'd0; sa_o = 12'd0; sw_o = 32'd0; rd_o = 32'd0; err_o = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (n > hold) en[d] = 1'b0;
      if (sram_en[d]) begin
        ens++;
        be_o = sram_be[d]; sa_o = sram_addr[d]; sw_o = sram_wd[d];
      end
      if (valid[d]) begin
        vals++;
        if (lat == 0) begin
          lat = n; rd_o = rdata[d]; err_o = err[d];
        end
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic [3:0]  x_be;
    logic [11:0] x_sa;
    logic [31:0] x_sw;
    logic        chk_rd;
    logic [31:0] x_rd;
    logic        x_err;
  } vec_t;

  vec_t vt[16];

  int lat, ens, vals;
  logic [3:0]  be_o;
  logic [11:0] sa_o;
  logic [31:0] sw_o, rd_o;
  logic        err_o;

  initial begin
    vt[0]  = '{1'b0, 32'h040,   4'hF, 32'h0,        4'h0, 12'h010, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    vt[1]  = '{1'b1, 32'h043,   4'h1, 32'hA5,       4'h8, 12'h010, 32'hA5000000, 1'b0, 32'h0,        1'b0};
    vt[2]  = '{1'b0, 32'h043,   4'h1, 32'h0,        4'h0, 12'h010, 32'h0,        1'b1, 32'h000000A5, 1'b0};
    vt[3]  = '{1'b1, 32'h102,   4'h3, 32'h1234,     4'hC, 12'h040, 32'h12340000, 1'b0, 32'h0,        1'b0};
    vt[4]  = '{1'b0, 32'h102,   4'h3, 32'h0,        4'h0, 12'h040, 32'h0,        1'b1, 32'h00001234, 1'b0};
    vt[5]  = '{1'b0, 32'h101,   4'h3, 32'h0,        4'h0, 12'h000, 32'h0,        1'b1, 32'h0,        1'b1};
    vt[6]  = '{1'b0, 32'h041,   4'hF, 32'h0,        4'h0, 12'h000, 32'h0,        1'b1, 32'h0,        1'b1};
    vt[7]  = '{1'b1, 32'h200,   4'hF, 32'hCAFEF00D, 4'hF, 12'h080, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0};
    vt[8]  = '{1'b0, 32'h200,   4'hF, 32'h0,        4'h0, 12'h080, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0};
    vt[9]  = '{1'b0, 32'h201,   4'h1, 32'h0,        4'h0, 12'h080, 32'h0,        1'b1, 32'h00CAFEF0, 1'b0};
    vt[10] = '{1'b1, 32'h204,   4'h0, 32'h11223344, 4'h0, 12'h081, 32'h11223344, 1'b0, 32'h0,        1'b0};
    vt[11] = '{1'b0, 32'h10040, 4'hF, 32'h0,        4'h0, 12'h010, 32'h0,        1'b1, 32'hA5ADBEEF, 1'b0};
    vt[12] = '{1'b1, 32'h205,   4'h1, 32'h77,       4'h2, 12'h081, 32'h00007700, 1'b0, 32'h0,        1'b0};
    vt[13] = '{1'b0, 32'h204,   4'h3, 32'h0,        4'h0, 12'h081, 32'h0,        1'b1, 32'h00007700, 1'b0};
    vt[14] = '{1'b1, 32'h103,   4'h3, 32'hFFFF,     4'h0, 12'h000, 32'h0,        1'b1, 32'h0,        1'b1};
    vt[15] = '{1'b0, 32'h100,   4'hF, 32'h0,        4'h0, 12'h040, 32'h0,        1'b1, 32'h12340000, 1'b0};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; en[d] = 1'b0; we[d] = 1'b0;
      addr[d] = 32'd0; strb[d] = 4'd0; wdat[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d_valid", d), {31'd0, valid[d]}, 32'd0);
      chk($sformatf("rst%0d_err", d), {31'd0, err[d]}, 32'd0);
      chk($sformatf("rst%0d_busy", d), {31'd0, busy[d]}, 32'd0);
      chk($sformatf("rst%0d_sram_en", d), {31'd0, sram_en[d]}, 32'd0);
      chk($sformatf("rst%0d_be", d), {28'd0, sram_be[d]}, 32'd0);
      chk($sformatf("rst%0d_addr", d), {20'd0, sram_addr[d]}, 32'd0);
      chk($sformatf("rst%0d_wdata", d), sram_wd[d], 32'd0);
      chk($sformatf("rst%0d_rdata", d), rdata[d], 32'd0);
      rst[d] = 1'b0;
    end

    // Table-driven vectors on the zero-wait instance
    for (int i = 0; i < 16; i++) begin
      run_req(0, vt[i].we, vt[i].addr, vt[i].strb, vt[i].wd, 0,
              lat, ens, vals, be_o, sa_o, sw_o, rd_o, err_o);
      chk($sformatf("v%0d_latency", i), lat, vt[i].x_err ? 32'd1 : 32'd3);
      chk($sformatf("v%0d_sram_en_count", i), ens, vt[i].x_err ? 32'd0 : 32'd1);
      chk($sformatf("v%0d_valid_count", i), vals, 32'd1);
      chk($sformatf("v%0d_err", i), {31'd0, err_o}, {31'd0, vt[i].x_err});
      if (!vt[i].x_err) begin
        chk($sformatf("v%0d_be", i), {28'd0, be_o}, {28'd0, vt[i].x_be});
        chk($sformatf("v%0d_sram_addr", i), {20'd0, sa_o}, {20'd0, vt[i].x_sa});
        chk($sformatf("v%0d_sram_wdata", i), sw_o, vt[i].x_sw);
      end
      if (vt[i].chk_rd) chk($sformatf("v%0d_rdata", i), rd_o, vt[i].x_rd);
    end

    // Back-to-back: B presented in A's RESP cycle, accepted only once IDLE
    begin
      int bn, blat, n_en, n_val;
      logic [31:0] ra, rb;
      bn = 0; blat = 0; n_en = 0; n_val = 0; ra = 32'd0; rb = 32'd0;
      @(negedge clk);
      en[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h040; strb[0] = 4'hF; wdat[0] = 32'd0;
      for (int n = 1; n <= 30; n++) begin
        @(negedge clk);
        if (bn == 0) en[0] = 1'b0;
        if (bn != 0 && n == bn + 2) en[0] = 1'b0;
        if (sram_en[0]) n_en++;
        if (valid[0]) begin
          n_val++;
          if (n_val == 1) begin
            ra = rdata[0];
            bn = n;
            en[0] = 1'b1; addr[0] = 32'h200;
          end else if (n_val == 2) begin
            rb = rdata[0];
            blat = n - bn;
          end
        end
      end
      chk("b2b_sram_en_count", n_en, 32'd2);
      chk("b2b_valid_count", n_val, 32'd2);
      chk("b2b_a_rdata", ra, 32'hA5ADBEEF);
      chk("b2b_b_rdata", rb, 32'hCAFEF00D);
      chk("b2b_b_latency", blat, 32'd4);
    end

    // WAIT_CYCLES=3 with en held two extra cycles after accept
    run_req(1, 1'b0, 32'h040, 4'hF, 32'd0, 2, lat, ens, vals, be_o, sa_o, sw_o, rd_o, err_o);
    chk("w3_latency", lat, 32'd6);
    chk("w3_sram_en_count", ens, 32'd1);
    chk("w3_valid_count", vals, 32'd1);
    chk("w3_rdata", rd_o, 32'hDEADBEEF);
    chk("w3_err", {31'd0, err_o}, 32'd0);

    // Reset pulsed while in WAIT: request is dropped silently
    begin
      int n_val;
      n_val = 0;
      @(negedge clk);
      en[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h040; strb[1] = 4'hF;
      @(negedge clk);
      en[1] = 1'b0;
      @(negedge clk);
      chk("abort_busy_in_wait", {31'd0, busy[1]}, 32'd1);
      rst[1] = 1'b1;
      @(negedge clk);
      rst[1] = 1'b0;
      chk("abort_busy", {31'd0, busy[1]}, 32'd0);
      chk("abort_sram_en", {31'd0, sram_en[1]}, 32'd0);
      for (int n = 0; n < 12; n++) begin
        if (valid[1]) n_val++;
        @(negedge clk);
      end
      chk("abort_valid_count", n_val, 32'd0);
    end
    run_req(1, 1'b0, 32'h040, 4'hF, 32'd0, 0, lat, ens, vals, be_o, sa_o, sw_o, rd_o, err_o);
    chk("post_abort_latency", lat, 32'd6);
    chk("post_abort_valid_count", vals, 32'd1);
    chk("post_abort_rdata", rd_o, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
